// File: rtl/m_fir_pkg.sv
// Shared types and arithmetic helpers for the FIR engine: FSM encoding,
// derived width helpers and the shift-then-saturate output function.
package m_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } fir_state_e;

    localparam int SAT_W = 64;

    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Arithmetic shift (rounds toward -inf), then clamp to a dw-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac,
        input int                      dw
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/m_fir_engine_tap_line.sv
// Sample history for the FIR engine: a CGES-deep signed shift register,
// newest sample at index 0, cleared only by reset.
module m_tap_line #(
    parameter int CGES = 7,
    parameter int DW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 shift_en_i,
    input  logic signed [DW-1:0] din_i,
    output logic signed [DW-1:0] taps_o [CGES]
);

    logic signed [DW-1:0] taps_q [CGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < CGES; k++) begin
                taps_q[k] <= '0;
            end
        end else if (shift_en_i) begin
            taps_q[0] <= din_i;
            for (int k = 1; k < CGES; k++) begin
                taps_q[k] <= taps_q[k-1];
            end
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/m_fir_engine.sv
// FIR engine: on a rising cal edge, shift in one sample, stream CGES
// coefficients from RAM, multiply-accumulate, saturate and pulse fin.
module m_fir_engine
    import m_fir_pkg::*;
#(
    parameter int CGES = 7,
    parameter int DW   = 16,
    parameter int FRAC = DW - 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cal,
    input  logic signed [DW-1:0]      x_data,
    output logic                      rd_en,
    output logic [$clog2(CGES)-1:0]   rd_addr,
    input  logic signed [DW-1:0]      rd_data,
    output logic                      busy,
    output logic                      fin,
    output logic signed [DW-1:0]      y,
    output logic                      y_valid
);

    localparam int AW   = addr_width(CGES);
    localparam int ACCW = acc_width(DW, CGES);

    fir_state_e state_q, state_d;
    logic       cal_q, arm_q, start;
    logic       rd_en_q, rd_en_d, rd_vld_q;
    logic       busy_q, busy_d, fin_q, fin_d;
    logic [AW-1:0] idx_q, didx_q, rd_addr_q;

    logic signed [DW-1:0]    taps [CGES];
    logic signed [2*DW-1:0]  prod;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic signed [SAT_W-1:0] acc_ext;
    logic signed [DW-1:0]    y_q, y_d;

    // arm_q blocks a spurious start when cal is already high as reset releases.
    assign start = (state_q == ST_IDLE) && cal && !cal_q && arm_q;

    m_tap_line #(.CGES(CGES), .DW(DW)) u_tap_line (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .shift_en_i (start),
        .din_i      (x_data),
        .taps_o     (taps)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (idx_q == AW'(CGES - 1)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en_d = (state_q == ST_READ);
        busy_d  = (state_d != ST_IDLE) || (state_q == ST_DONE);
        fin_d   = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cal_q     <= 1'b0;
            arm_q     <= 1'b0;
            idx_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            cal_q    <= cal;
            arm_q    <= arm_q | ~cal;
            rd_en_q  <= rd_en_d;
            rd_vld_q <= rd_en_q;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
            if (start) begin
                idx_q <= '0;
            end else if (state_q == ST_READ) begin
                idx_q     <= idx_q + AW'(1);
                rd_addr_q <= idx_q;
            end
        end
    end

    // Data returning in this cycle pairs with the tap of the same index.
    assign prod    = rd_data * taps[didx_q];
    assign acc_d   = acc_q + {{AW{prod[2*DW-1]}}, prod};
    assign acc_ext = {{(SAT_W - ACCW){acc_d[ACCW-1]}}, acc_d};
    assign y_d     = DW'(sat_shift(acc_ext, FRAC, DW));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            didx_q <= '0;
            y_q    <= '0;
        end else begin
            if (start) begin
                acc_q  <= '0;
                didx_q <= '0;
            end else if (rd_vld_q) begin
                acc_q  <= acc_d;
                didx_q <= didx_q + AW'(1);
            end
            if (state_q == ST_DONE) begin
                y_q <= y_d;
            end
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign fin     = fin_q;
    assign y_valid = fin_q;
    assign y       = y_q;

endmodule
